// File: rtl/spi_buffer_avalon_debugger_pkg.sv
// Shared constants for the SPI buffer debugger: Avalon address map,
// register field positions and an address-region decode helper.
package spi_buffer_avalon_debugger_pkg;

  // Avalon word address map
  localparam int unsigned ADDR_STATUS   = 0;
  localparam int unsigned ADDR_EVENTS   = 1;
  localparam int unsigned ADDR_LOG_BASE = 2;

  // STATUS word fields
  localparam int unsigned STATUS_OVF_BIT = 63;
  localparam int unsigned STATUS_CNT_LSB = 0;
  localparam int unsigned CNT_W          = 9;

  // EVENTS word fields
  localparam int unsigned EVT_LSB  = 0;
  localparam int unsigned EVT_W    = 32;
  localparam int unsigned LAST_LSB = 32;
  localparam int unsigned LAST_W   = 8;

  typedef enum logic [1:0] {
    REGION_STATUS,
    REGION_EVENTS,
    REGION_LOG,
    REGION_NONE
  } region_e;

  // Classify a 7-bit word address given the number of log words.
  function automatic region_e decode_region(input logic [6:0] addr,
                                            input int unsigned words);
    int unsigned a;
    a = 32'(addr);
    if (a == ADDR_STATUS)                                   return REGION_STATUS;
    else if (a == ADDR_EVENTS)                              return REGION_EVENTS;
    else if (a >= ADDR_LOG_BASE && a < ADDR_LOG_BASE + words) return REGION_LOG;
    else                                                    return REGION_NONE;
  endfunction

endpackage

// File: rtl/spi_buffer_avalon_debugger_if.sv
// Avalon-MM read-only slave bundle for the SPI buffer debugger.
//   address  : word address (master -> slave)
//   read     : read strobe   (master -> slave)
//   readdata : registered read data (slave -> master)
interface spi_buffer_avalon_debugger_if;
  logic [6:0]  address;
  logic        read;
  logic [63:0] readdata;

  modport master (output address, output read, input readdata);
  modport slave  (input address, input read, output readdata);
endinterface

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk      : sampling clock
//   rst_n    : asynchronous active-low reset
//   async_in : level from another clock domain
//   rise     : one-cycle pulse per synchronized low-to-high transition
// An input already high when reset is released is not reported until it
// has been observed low at least once.
module sync_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [1:0] fill;   // tracks when sync2 carries real sampled data
  logic       armed;  // set once the synchronized input has been seen low

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && !sync2) armed <= 1'b1;
    end
  end

  always_comb begin
    rise = armed & sync2 & ~prev;
  end

endmodule

// File: rtl/spi_buffer_avalon_debugger.sv
// Capture log for bytes produced by an upstream SPI shift buffer, exposed
// through a read-only Avalon-MM slave with one-cycle registered reads.
//   clock             : single clock, rising edge
//   reset             : asynchronous active-low reset
//   io_InputBuffer    : latest byte from the SPI buffer
//   io_BufferChanged  : asynchronous "new byte" level
//   io_Avalon_address : word address (0 status, 1 events, 2.. log words)
//   io_Avalon_read    : read strobe
//   io_Avalon_readdata: registered read data, held while read is low
module spi_buffer_avalon_debugger
  import spi_buffer_avalon_debugger_pkg::*;
#(
  parameter int unsigned LOG_BYTES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_InputBuffer,
  input  logic        io_BufferChanged,
  input  logic [6:0]  io_Avalon_address,
  input  logic        io_Avalon_read,
  output logic [63:0] io_Avalon_readdata
);

  localparam int unsigned WORDS = LOG_BYTES / 8;
  localparam int unsigned WIDX  = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic                  edge_det;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf;
  logic [EVT_W-1:0]      evt;
  logic [LAST_W-1:0]     last;
  logic [63:0]           log_mem [WORDS];
  logic [WORDS-1:0][7:0] lane_we;
  logic                  full;
  logic                  store;
  logic [WIDX-1:0]       wr_word;
  logic [2:0]            wr_lane;
  logic [6:0]            rd_idx;
  logic [63:0]           rd_next;

  sync_rise_detect u_sync (
    .clk      (clock),
    .rst_n    (reset),
    .async_in (io_BufferChanged),
    .rise     (edge_det)
  );

  always_comb begin
    full    = (cnt == CNT_W'(LOG_BYTES));
    store   = edge_det & ~full;
    wr_lane = cnt[2:0];
    wr_word = WIDX'(cnt >> 3);
    lane_we = '0;
    if (store) lane_we[wr_word][wr_lane] = 1'b1;
  end

  // Capture state and log array
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      ovf  <= 1'b0;
      evt  <= '0;
      last <= '0;
      for (int unsigned w = 0; w < WORDS; w++) log_mem[w] <= '0;
    end else begin
      if (edge_det) begin
        last <= io_InputBuffer;
        if (evt != '1) evt <= evt + 1'b1;
        if (full) ovf <= 1'b1;
        else      cnt <= cnt + 1'b1;
      end
      for (int unsigned w = 0; w < WORDS; w++) begin
        for (int unsigned b = 0; b < 8; b++) begin
          if (lane_we[w][b]) log_mem[w][8*b +: 8] <= io_InputBuffer;
        end
      end
    end
  end

  // Read mux; sampled from current register state, so a same-cycle
  // capture is not visible until the following read.
  always_comb begin
    rd_next = '0;
    rd_idx  = io_Avalon_address - 7'(ADDR_LOG_BASE);
    case (decode_region(io_Avalon_address, WORDS))
      REGION_STATUS: begin
        rd_next[STATUS_OVF_BIT]         = ovf;
        rd_next[STATUS_CNT_LSB +: CNT_W] = cnt;
      end
      REGION_EVENTS: begin
        rd_next[EVT_LSB +: EVT_W]   = evt;
        rd_next[LAST_LSB +: LAST_W] = last;
      end
      REGION_LOG:  rd_next = log_mem[rd_idx[WIDX-1:0]];
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              io_Avalon_readdata <= '0;
    else if (io_Avalon_read) io_Avalon_readdata <= rd_next;
  end

endmodule

// File: tb/tb_spi_buffer_avalon_debugger.sv
// Directed self-checking bench for spi_buffer_avalon_debugger.
module tb_spi_buffer_avalon_debugger;

  logic       clock;
  logic       reset;
  logic [7:0] in_buf;
  logic       chg;
  int         checks;
  int         failures;
  logic [63:0] rd;

  spi_buffer_avalon_debugger_if av ();

  spi_buffer_avalon_debugger #(.LOG_BYTES(256)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_InputBuffer     (in_buf),
    .io_BufferChanged   (chg),
    .io_Avalon_address  (av.address),
    .io_Avalon_read     (av.read),
    .io_Avalon_readdata (av.readdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [7:0] b);
    @(negedge clock);
    in_buf = b;
    chg    = 1'b1;
    repeat (4) @(negedge clock);
    chg = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic do_read(input logic [6:0] a, output logic [63:0] d);
    @(negedge clock);
    av.address = a;
    av.read    = 1'b1;
    @(posedge clock);
    #1;
    d = av.readdata;
    @(negedge clock);
    av.read = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  initial begin
    logic [63:0] exp_log [10];
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    in_buf     = '0;
    chg        = 1'b0;
    av.address = '0;
    av.read    = 1'b0;

    // reset state
    repeat (3) @(negedge clock);
    check("reset_readdata", av.readdata, 64'h0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    do_read(7'd0, rd); check("idle_status", rd, 64'h0);
    do_read(7'd1, rd); check("idle_events", rd, 64'h0);

    // four captures, then read addresses 0..9
    capture(8'h7A); capture(8'h80); capture(8'h0C); capture(8'h40);
    exp_log[0] = 64'h0000000000000004;
    exp_log[1] = 64'h0000004000000004;
    exp_log[2] = 64'h00000000400C807A;
    for (int i = 3; i < 10; i++) exp_log[i] = 64'h0;
    for (int i = 0; i < 10; i++) begin
      do_read(7'(i), rd);
      check($sformatf("four_bytes_addr%0d", i), rd, exp_log[i]);
    end

    // readdata holds while read is low; unmapped address reads zero
    do_read(7'd0, rd); check("status_before_hold", rd, 64'h4);
    @(negedge clock);
    av.address = 7'd100;
    repeat (3) @(negedge clock);
    check("hold_while_read_low", av.readdata, 64'h4);
    do_read(7'd100, rd); check("addr100_zero", rd, 64'h0);
    av.address = 7'd2;
    repeat (3) @(negedge clock);
    check("hold_zero_while_low", av.readdata, 64'h0);

    // three more captures, then reset mid-operation
    capture(8'hA1); capture(8'hA2); capture(8'hA3);
    do_read(7'd2, rd); check("word0_seven_bytes", rd, 64'h00A3A2A1400C807A);
    @(negedge clock);
    reset = 1'b0;
    chg   = 1'b1;   // held high across reset release
    #1;
    check("async_reset_readdata", av.readdata, 64'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    do_read(7'd0, rd); check("no_edge_high_at_release", rd, 64'h0);
    do_read(7'd2, rd); check("log_cleared", rd, 64'h0);
    chg = 1'b0;
    repeat (4) @(negedge clock);
    capture(8'h11);
    do_read(7'd0, rd); check("after_reset_status", rd, 64'h1);
    do_read(7'd2, rd); check("after_reset_word0", rd, 64'h11);

    // long high level yields a single capture
    do_reset();
    @(negedge clock);
    in_buf = 8'h55;
    chg    = 1'b1;
    repeat (20) @(negedge clock);
    chg = 1'b0;
    repeat (4) @(negedge clock);
    do_read(7'd0, rd); check("hold20_cnt", rd, 64'h1);
    do_read(7'd1, rd); check("hold20_events", rd, 64'h0000005500000001);
    do_read(7'd2, rd); check("hold20_byte", {56'h0, rd[7:0]}, 64'h55);

    // fill the log and overflow by one
    do_reset();
    for (int k = 0; k < 257; k++) capture(8'(k));
    do_read(7'd0,  rd); check("full_status", rd, 64'h8000000000000100);
    do_read(7'd1,  rd); check("full_events", rd, 64'h0000000000000101);
    do_read(7'd2,  rd); check("full_word0", rd, 64'h0706050403020100);
    do_read(7'd33, rd); check("full_word31", rd, 64'hFFFEFDFCFBFAF9F8);
    do_read(7'd34, rd); check("past_log_zero", rd, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
